laser500_reset_seq: RTL and testbench
=====================================

# laser500_reset_seq

Parametrised power-on/reset sequencer for the Laser 500 core. It sits between the PLL, OSD status, keyboard and ROM downloader on one side, and the CPU, VTL chip, audio DAC and cassette latch on the other. It replaces a single hard-coded hold counter with a state machine that provides:
- a configurable hold time;
- N staggered reset channels;
- OSD-triggered restart;
- a hold freeze during ROM download;
- a registered CPU WAIT_n.

## Interface
Parameters:
- HOLD_CYCLES, 9000000: F14M cycles of global hold after PLL lock before any channel is released.
- NUM_OUT, 3: reset channels. Channel 0 is the CPU; higher channels release later.
- STAGGER_CYCLES, 16: cycles between successive channel releases. 0 releases all channels together.
- CNT_W, 24: counter width. Must satisfy 2^CNT_W > max(HOLD_CYCLES, STAGGER_CYCLES*NUM_OUT).
- SYNC_STAGES, 2: synchroniser depth for pll_locked.

Ports:
- F14M  in  1  system clock, 14.77873 MHz.
- RESET_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock; asynchronous, synchronised internally.
- st_reset  in  1  OSD status reset bit, level. Its rising edge restarts the sequence.
- reset_key  in  1  keyboard reset, synchronous level. Affects channel 0 only.
- is_downloading  in  1  ROM/PRG download active, synchronous.
- rst_out  out  NUM_OUT  active-high per-channel resets.
- wait_n  out  1  CPU WAIT_n.
- running  out  1  high when the sequencer is in RUN.

## Operation
- States: WAIT_PLL, HOLD, RELEASE, RUN. Encoding is one-hot or binary, implementer's choice.
- WAIT_PLL:
  - Counter is 0 and all rst_out are 1.
  - Go to HOLD when synchronised lock = 1.
- HOLD:
  - Counter increments each cycle while is_downloading = 0 and freezes while is_downloading = 1.
  - When counter = HOLD_CYCLES-1 and not frozen, clear the counter and go to RELEASE.
- RELEASE:
  - Counter increments every cycle, with no freeze.
  - rst_out[i] clears on the cycle the counter equals STAGGER_CYCLES*i.
  - When rst_out[NUM_OUT-1] clears, go to RUN.
- RUN: all channels released, except channel 0 as described below. running = 1.
- Loss of synchronised lock, in any state: go to WAIT_PLL. All rst_out = 1 on the next edge.
- OSD restart:
  - Triggered by a rising edge of st_reset, using a registered previous value.
  - In any state other than WAIT_PLL: go to HOLD, counter = 0, all rst_out = 1.
  - Lock loss has priority over OSD restart.
- Channel 0 output is (sequencer reset for channel 0) OR reset_key. reset_key never changes state or counter.
- wait_n is registered: ~(is_downloading | rst_out[0]).
- running is registered and equals (state == RUN).
- The edge detector and synchroniser are cleared by RESET_n, so st_reset held high through reset produces no edge.

## Timing
- RESET_n low, asynchronously: state WAIT_PLL, counter 0, rst_out all 1, wait_n 0, running 0, synchroniser 0, st_reset history 0.
- pll_locked rise to HOLD entry: SYNC_STAGES+1 edges.
- HOLD duration: exactly HOLD_CYCLES non-frozen cycles.
- rst_out[0] falls on the first edge after HOLD exit.
- rst_out[i] falls STAGGER_CYCLES*i cycles after rst_out[0].
- running rises one cycle after rst_out[NUM_OUT-1] falls.
- OSD edge to all rst_out high: 2 edges (edge register, then state register).
- reset_key to rst_out[0]: 1 edge; release also 1 edge.
- wait_n lags its inputs by 1 edge.
- Counter never wraps:
  - HOLD clears the counter at its terminal count.
  - RELEASE stops at STAGGER_CYCLES*(NUM_OUT-1).
- Simultaneous freeze and terminal count: the freeze wins, so the sequencer stays in HOLD.

## Structure
- Shared package laser500_pkg holds:
  - state typedef seq_state_t;
  - F14M_HZ constant;
  - channel index constants RST_CPU=0, RST_VTL=1, RST_AUDIO=2.
- One natural sub-module, sync_bit #(SYNC_STAGES): the flop-chain synchroniser for pll_locked. Everything else is flat.

## Test plan
All scenarios use HOLD_CYCLES=100, NUM_OUT=3, STAGGER_CYCLES=4 unless noted.
- Power-up: release RESET_n, then raise pll_locked at t0.
  - rst_out[0] falls at t0+3+100+1.
  - rst_out[1] falls 4 cycles later; rst_out[2] falls 8 cycles later.
  - running rises 1 cycle after rst_out[2] falls.
- Download freeze: is_downloading high for 50 cycles mid-HOLD.
  - Release is delayed by exactly 50 cycles.
  - wait_n stays 0 throughout the download.
- OSD restart: pulse st_reset in RUN.
  - All rst_out go to 1 within 2 edges.
  - A full 100-cycle HOLD repeats.
  - Holding st_reset high afterwards causes no further restart.
- Lock loss: drop pll_locked in RELEASE after channel 0 is released.
  - All rst_out go to 1 after the synchroniser delay, and state is WAIT_PLL.
  - Lock loss in the same cycle as an OSD edge goes to WAIT_PLL.
- Keyboard reset: reset_key high for 10 cycles in RUN.
  - Only rst_out[0] = 1 for 10 cycles, delayed by 1 edge.
  - running stays 1.
- STAGGER_CYCLES=0, NUM_OUT=4: all four channels fall on the same edge. Asserting RESET_n mid-HOLD returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/laser500_pkg.sv
// laser500_pkg: shared types and constants for the Laser 500 reset sequencer
package laser500_pkg;
  typedef enum logic [1:0] {
    S_WAIT_PLL = 2'd0,
    S_HOLD     = 2'd1,
    S_RELEASE  = 2'd2,
    S_RUN      = 2'd3
  } seq_state_t;
  localparam int F14M_HZ   = 14778730;
  localparam int RST_CPU   = 0;
  localparam int RST_VTL   = 1;
  localparam int RST_AUDIO = 2;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: flop-chain synchroniser for a single asynchronous level
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_ff;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ff <= '0;
    else r_ff <= STAGES'({r_ff, i_d});
  end
  assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/laser500_reset_seq.sv
// laser500_reset_seq: PLL-gated hold, staggered channel release, OSD restart and CPU WAIT_n
module laser500_reset_seq
  import laser500_pkg::*;
#(
  parameter int HOLD_CYCLES    = 9000000,
  parameter int NUM_OUT        = 3,
  parameter int STAGGER_CYCLES = 16,
  parameter int CNT_W          = 24,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               F14M,
  input  logic               RESET_n,
  input  logic               pll_locked,
  input  logic               st_reset,
  input  logic               reset_key,
  input  logic               is_downloading,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               wait_n,
  output logic               running
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(STAGGER_CYCLES * (NUM_OUT - 1));
  seq_state_t         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_OUT-1:0] r_seq_rst;
  logic               r_st_prev;
  logic               r_osd_edge;
  logic               r_key;
  logic               r_wait_n;
  logic               r_running;
  logic               w_locked;
  logic [NUM_OUT-1:0] w_rel_clr;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .i_clk   (F14M),
    .i_rst_n (RESET_n),
    .i_d     (pll_locked),
    .o_q     (w_locked)
  );
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_rel
    assign w_rel_clr[i] = (r_state == S_RELEASE) && (r_cnt == CNT_W'(STAGGER_CYCLES * i));
  end
  // The keyboard only ever holds the CPU; it never touches sequencer state.
  assign rst_out = r_seq_rst | (NUM_OUT'(r_key) << RST_CPU);
  assign wait_n  = r_wait_n;
  assign running = r_running;
  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= S_WAIT_PLL;
      r_cnt      <= '0;
      r_seq_rst  <= '1;
      r_st_prev  <= 1'b0;
      r_osd_edge <= 1'b0;
      r_key      <= 1'b0;
      r_wait_n   <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_st_prev  <= st_reset;
      r_osd_edge <= st_reset & ~r_st_prev;
      r_key      <= reset_key;
      r_wait_n   <= ~(is_downloading | rst_out[RST_CPU]);
      r_running  <= r_state == S_RUN;
      if (!w_locked) begin
        r_state   <= S_WAIT_PLL;
        r_cnt     <= '0;
        r_seq_rst <= '1;
      end else if (r_osd_edge && r_state != S_WAIT_PLL) begin
        r_state   <= S_HOLD;
        r_cnt     <= '0;
        r_seq_rst <= '1;
      end else begin
        case (r_state)
          S_WAIT_PLL: begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end
          S_HOLD: begin
            if (!is_downloading) begin
              r_state <= r_cnt == HOLD_LAST ? S_RELEASE : S_HOLD;
              r_cnt   <= r_cnt == HOLD_LAST ? '0 : r_cnt + CNT_W'(1);
            end
          end
          S_RELEASE: begin
            r_seq_rst <= r_seq_rst & ~w_rel_clr;
            r_cnt     <= r_cnt == REL_LAST ? r_cnt : r_cnt + CNT_W'(1);
            if (w_rel_clr[NUM_OUT-1]) r_state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_laser500_reset_seq.sv
// tb_laser500_reset_seq: directed scenarios with a cycle-tagged expectation scoreboard
module tb_laser500_reset_seq;
  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b, lock_a, lock_b, st_reset, reset_key, dl;
  logic [2:0] rst_a;
  logic [3:0] rst_b;
  logic       wn_a, wn_b, run_a, run_b;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  typedef struct {
    int         at;
    bit         dut;
    logic [5:0] v;
    string      name;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  laser500_reset_seq #(
    .HOLD_CYCLES(100), .NUM_OUT(3), .STAGGER_CYCLES(4), .CNT_W(8), .SYNC_STAGES(2)
  ) dut_a (
    .F14M(clk), .RESET_n(rst_n_a), .pll_locked(lock_a), .st_reset(st_reset),
    .reset_key(reset_key), .is_downloading(dl), .rst_out(rst_a), .wait_n(wn_a), .running(run_a)
  );
  laser500_reset_seq #(
    .HOLD_CYCLES(100), .NUM_OUT(4), .STAGGER_CYCLES(0), .CNT_W(8), .SYNC_STAGES(2)
  ) dut_b (
    .F14M(clk), .RESET_n(rst_n_b), .pll_locked(lock_b), .st_reset(1'b0),
    .reset_key(1'b0), .is_downloading(1'b0), .rst_out(rst_b), .wait_n(wn_b), .running(run_b)
  );
  wire [5:0] vec_a = {run_a, wn_a, 1'b0, rst_a};
  wire [5:0] vec_b = {run_b, wn_b, rst_b};
  // Outputs are presented every cycle; expectations tagged with that cycle are retired here.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        logic [5:0] a;
        a = q[i].dut ? vec_b : vec_a;
        checks++;
        if (q[i].at < cyc) begin
          failures++;
          $display("FAIL %s missed cycle %0d", q[i].name, q[i].at);
        end else if (a !== q[i].v) begin
          failures++;
          $display("FAIL %s cyc=%0d got {run,wn,rst}=%b want=%b", q[i].name, cyc, a, q[i].v);
        end
        q.delete(i);
      end
    end
  end
  task automatic ex(input int at, input bit dut, input logic [5:0] v, input string name);
    exp_t e;
    e.at = at; e.dut = dut; e.v = v; e.name = name;
    q.push_back(e);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic restart(output int h);
    st_reset = 1'b0;
    step(1);
    st_reset = 1'b1;
    h = cyc + 2;
  endtask
  initial begin
    int t, c, h, r, x, b;
    rst_n_a = 0; rst_n_b = 0; lock_a = 0; lock_b = 0;
    st_reset = 0; reset_key = 0; dl = 0;
    step(2);
    ex(cyc, 0, 6'b00_0111, "reset_a");
    ex(cyc, 1, 6'b00_1111, "reset_b");
    rst_n_a = 1;
    ex(cyc + 2, 0, 6'b00_0111, "wait_pll");
    step(3);
    t = cyc; lock_a = 1;
    ex(t + 103, 0, 6'b00_0111, "pwr_hold_end");
    ex(t + 104, 0, 6'b00_0110, "pwr_rst0");
    ex(t + 105, 0, 6'b01_0110, "pwr_wait_n");
    ex(t + 107, 0, 6'b01_0110, "pwr_rst1_hold");
    ex(t + 108, 0, 6'b01_0100, "pwr_rst1");
    ex(t + 111, 0, 6'b01_0100, "pwr_rst2_hold");
    ex(t + 112, 0, 6'b01_0000, "pwr_rst2");
    ex(t + 113, 0, 6'b11_0000, "pwr_running");
    step(115);
    c = cyc; reset_key = 1;
    ex(c,      0, 6'b11_0000, "key_before");
    ex(c + 1,  0, 6'b11_0001, "key_rst0");
    ex(c + 2,  0, 6'b10_0001, "key_wait_n");
    ex(c + 10, 0, 6'b10_0001, "key_held");
    ex(c + 11, 0, 6'b10_0000, "key_release");
    ex(c + 12, 0, 6'b11_0000, "key_wait_n_back");
    step(10);
    reset_key = 0;
    step(4);
    c = cyc; st_reset = 1;
    ex(c + 1,   0, 6'b11_0000, "osd_edge_reg");
    ex(c + 2,   0, 6'b11_0111, "osd_all_rst");
    ex(c + 3,   0, 6'b00_0111, "osd_not_run");
    ex(c + 102, 0, 6'b00_0111, "osd_hold_end");
    ex(c + 103, 0, 6'b00_0110, "osd_rst0");
    ex(c + 104, 0, 6'b01_0110, "osd_wait_n");
    ex(c + 107, 0, 6'b01_0100, "osd_rst1");
    ex(c + 111, 0, 6'b01_0000, "osd_rst2");
    ex(c + 112, 0, 6'b11_0000, "osd_running");
    ex(c + 140, 0, 6'b11_0000, "osd_level_no_restart");
    step(142);
    restart(h);
    ex(h, 0, 6'b11_0111, "dl_restart");
    step(22);
    dl = 1;
    ex(h + 30,  0, 6'b00_0111, "dl_frozen");
    ex(h + 70,  0, 6'b00_0111, "dl_last");
    step(50);
    dl = 0;
    ex(h + 101, 0, 6'b00_0111, "dl_no_early");
    ex(h + 150, 0, 6'b00_0111, "dl_hold_end");
    ex(h + 151, 0, 6'b00_0110, "dl_rst0");
    ex(h + 152, 0, 6'b01_0110, "dl_wait_n");
    ex(h + 159, 0, 6'b01_0000, "dl_rst2");
    ex(h + 160, 0, 6'b11_0000, "dl_running");
    step(92);
    restart(h);
    step(101);
    dl = 1;
    ex(h + 101, 0, 6'b00_0111, "tc_freeze_wins");
    ex(h + 105, 0, 6'b00_0111, "tc_hold_end");
    ex(h + 106, 0, 6'b00_0110, "tc_rst0");
    ex(h + 107, 0, 6'b01_0110, "tc_wait_n");
    ex(h + 115, 0, 6'b11_0000, "tc_running");
    step(5);
    dl = 0;
    step(15);
    restart(h);
    step(104);
    lock_a = 0;
    ex(h + 102, 0, 6'b01_0110, "ll_released0");
    ex(h + 104, 0, 6'b01_0110, "ll_sync_delay");
    ex(h + 105, 0, 6'b01_0111, "ll_all_rst");
    ex(h + 106, 0, 6'b00_0111, "ll_wait_n");
    ex(h + 130, 0, 6'b00_0111, "ll_stay");
    step(30);
    r = cyc; lock_a = 1;
    ex(r + 103, 0, 6'b00_0111, "relock_hold_end");
    ex(r + 104, 0, 6'b00_0110, "relock_rst0");
    ex(r + 113, 0, 6'b11_0000, "relock_running");
    step(115);
    st_reset = 0;
    step(2);
    x = cyc; lock_a = 0;
    step(1);
    lock_a = 1; st_reset = 1;
    ex(x + 2,   0, 6'b11_0000, "prio_before");
    ex(x + 3,   0, 6'b11_0111, "prio_all_rst");
    ex(x + 4,   0, 6'b00_0111, "prio_stopped");
    ex(x + 104, 0, 6'b00_0111, "prio_via_wait_pll");
    ex(x + 105, 0, 6'b00_0110, "prio_rst0");
    ex(x + 114, 0, 6'b11_0000, "prio_running");
    step(116);
    b = cyc; rst_n_b = 1; lock_b = 1;
    step(50);
    rst_n_b = 0;
    ex(cyc, 1, 6'b00_1111, "b_async_hold");
    step(2);
    b = cyc; rst_n_b = 1;
    ex(b + 103, 1, 6'b00_1111, "b_hold_end");
    ex(b + 104, 1, 6'b00_0000, "b_all_fall");
    ex(b + 105, 1, 6'b11_0000, "b_running");
    step(110);
    rst_n_b = 0;
    ex(cyc, 1, 6'b00_1111, "b_async_run");
    step(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
